// File: rtl/wb_writer.sv
// wb_writer: in-order writeback queue driving the register file write port, with a
// two-port newest-first bypass lookup. Define WB_MERGE_EN to coalesce writes to a queued register.
module wb_writer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_wa,
    input  logic [DW-1:0]          in_data,
    input  logic                   drain_en,
    output logic                   regwrite,
    output logic [AW-1:0]          wa,
    output logic [DW-1:0]          write_data,
    input  logic [AW-1:0]          ra1,
    input  logic [AW-1:0]          ra2,
    output logic                   hit1,
    output logic [DW-1:0]          byp1,
    output logic                   hit2,
    output logic [DW-1:0]          byp2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] q_wa   [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic [PW-1:0] slot_idx [DEPTH];
    logic          slot_vld [DEPTH];

    logic          pop;
    logic          accept;
    logic          alloc;
    logic          merge_wr;
    logic [PW-1:0] merge_idx;

    // Handshake: a result transfers at a rising edge where in_valid && in_ready;
    // in_valid may be held or dropped freely, in_ready never waits on in_valid.

    // Slot i is the i-th oldest pending entry; slot DEPTH-1 side is youngest.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_idx[i] = rd_ptr + PW'(i);
            slot_vld[i] = CW'(i) < count;
        end
    end

    assign pop = drain_en && (count != '0);

`ifdef WB_MERGE_EN
    logic merge_hit;
    logic merge_ok;

    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (q_wa[slot_idx[i]] == in_wa)) begin
                merge_hit = 1'b1;
                merge_idx = slot_idx[i];
            end
        end
    end

    // The entry leaving this cycle cannot absorb the write; it must allocate instead.
    assign merge_ok = merge_hit && !(pop && (merge_idx == rd_ptr));
    assign in_ready = (count < FULL) || merge_ok;
    assign merge_wr = in_valid && merge_ok;
`else
    assign merge_idx = '0;
    assign in_ready  = count < FULL;
    assign merge_wr  = 1'b0;
`endif

    assign accept = in_valid && in_ready;
    // r0 results are consumed by the handshake but never occupy a slot.
    assign alloc  = accept && !merge_wr && (in_wa != '0);
    assign empty  = (count == '0) && !regwrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            regwrite   <= 1'b0;
            wa         <= '0;
            write_data <= '0;
        end else begin
            regwrite <= pop;
            if (pop) begin
                wa         <= q_wa[rd_ptr];
                write_data <= q_data[rd_ptr];
                rd_ptr     <= rd_ptr + PW'(1);
            end
            if (alloc) begin
                q_wa[wr_ptr]   <= in_wa;
                q_data[wr_ptr] <= in_data;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (merge_wr) begin
                q_data[merge_idx] <= in_data;
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

    // Younger queue entries override older ones, and any queue entry overrides the output register.
    always_comb begin
        hit1 = 1'b0;
        byp1 = '0;
        hit2 = 1'b0;
        byp2 = '0;
        if (regwrite && (wa == ra1)) begin
            hit1 = 1'b1;
            byp1 = write_data;
        end
        if (regwrite && (wa == ra2)) begin
            hit2 = 1'b1;
            byp2 = write_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (q_wa[slot_idx[i]] == ra1)) begin
                hit1 = 1'b1;
                byp1 = q_data[slot_idx[i]];
            end
            if (slot_vld[i] && (q_wa[slot_idx[i]] == ra2)) begin
                hit2 = 1'b1;
                byp2 = q_data[slot_idx[i]];
            end
        end
        if (ra1 == '0) begin
            hit1 = 1'b0;
            byp1 = '0;
        end
        if (ra2 == '0) begin
            hit2 = 1'b0;
            byp2 = '0;
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a queue-based model (follows WB_MERGE_EN when defined).
module tb_wb_writer;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_wa;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          regwrite;
    logic [AW-1:0] wa;
    logic [DW-1:0] write_data;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          hit1;
    logic [DW-1:0] byp1;
    logic          hit2;
    logic [DW-1:0] byp2;
    logic [$clog2(DEPTH):0] count;
    logic          empty;

    int n_chk  = 0;
    int n_fail = 0;

    wb_writer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wa(in_wa), .in_data(in_data),
        .drain_en(drain_en),
        .regwrite(regwrite), .wa(wa), .write_data(write_data),
        .ra1(ra1), .ra2(ra2),
        .hit1(hit1), .byp1(byp1), .hit2(hit2), .byp2(byp2),
        .count(count), .empty(empty)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model: pending writes as {wa, data}, oldest at index 0, plus the output register
    logic [AW+DW-1:0] exp_q[$];
    logic             m_rw;
    logic [AW-1:0]    m_wa;
    logic [DW-1:0]    m_wd;
    bit               chk_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int youngest_match(input logic [AW-1:0] a);
        int j;
        logic [AW+DW-1:0] e;
        j = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            e = exp_q[k];
            if (e[AW+DW-1:DW] == a) j = k;
        end
        return j;
    endfunction

    function automatic bit merge_usable();
`ifdef WB_MERGE_EN
        int j;
        j = youngest_match(in_wa);
        return (j >= 0) && !(drain_en && j == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        return (exp_q.size() < DEPTH) || merge_usable();
    endfunction

    function automatic logic [DW:0] model_byp(input logic [AW-1:0] ra);
        logic [AW+DW-1:0] e;
        if (ra == '0) return '0;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            e = exp_q[k];
            if (e[AW+DW-1:DW] == ra) return {1'b1, e[DW-1:0]};
        end
        if (m_rw && m_wa == ra) return {1'b1, m_wd};
        return '0;
    endfunction

    always @(posedge clk) begin : model_update
        bit acc;
        bit mrg;
        int j;
        logic [AW+DW-1:0] e;
        if (rst) begin
            exp_q.delete();
            m_rw   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
            chk_on = 1'b1;
        end else if (chk_on) begin
            acc = in_valid && model_ready();
            mrg = acc && merge_usable();
            if (mrg) begin
                j = youngest_match(in_wa);
                e = exp_q[j];
                e[DW-1:0] = in_data;
                exp_q[j] = e;
            end
            if (drain_en && exp_q.size() > 0) begin
                m_rw = 1'b1;
                {m_wa, m_wd} = exp_q.pop_front();
            end else begin
                m_rw = 1'b0;
            end
            if (acc && !mrg && in_wa != '0) exp_q.push_back({in_wa, in_data});
        end
    end

    // compare process: every cycle, after inputs for the cycle have settled
    always @(negedge clk) begin : compare
        logic [DW:0] b;
        #2;
        if (chk_on) begin
            chk("regwrite", 32'(regwrite), 32'(m_rw));
            chk("wa", 32'(wa), 32'(m_wa));
            chk("write_data", write_data, m_wd);
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("empty", 32'(empty), 32'(exp_q.size() == 0 && !m_rw));
            chk("in_ready", 32'(in_ready), 32'(model_ready()));
            b = model_byp(ra1);
            chk("hit1", 32'(hit1), 32'(b[DW]));
            chk("byp1", byp1, b[DW-1:0]);
            b = model_byp(ra2);
            chk("hit2", 32'(hit2), 32'(b[DW]));
            chk("byp2", byp2, b[DW-1:0]);
        end
    end

    // driver tasks
    task automatic step(input logic r, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic dr, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_wa    = a;
        in_data  = d;
        drain_en = dr;
        ra1      = r1;
        ra2      = r2;
        #3;
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 1'b0, '0, '0, dr, '0, '0);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b0, 1'b1, a, d, 1'b0, '0, '0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_wa = '0; in_data = '0; drain_en = 1'b0; ra1 = '0; ra2 = '0;

        // reset then idle
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(1'b0);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hit1", 32'(hit1), 32'd0);

        // single write
        step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, '0, '0);
        idle(1'b1);
        chk("single_count", 32'(count), 32'd1);
        chk("single_rw_early", 32'(regwrite), 32'd0);
        idle(1'b1);
        chk("single_rw", 32'(regwrite), 32'd1);
        chk("single_wa", 32'(wa), 32'd3);
        chk("single_wd", write_data, 32'hDEADBEEF);
        idle(1'b1);
        chk("single_rw_off", 32'(regwrite), 32'd0);
        chk("single_empty", 32'(empty), 32'd1);

        // fill and backpressure
        for (int k = 1; k <= 4; k++) push(5'(k), 32'(k * 'h11));
        idle(1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        idle(1'b1);
        for (int k = 1; k <= 4; k++) begin
            idle(1'b1);
            chk("fill_rw", 32'(regwrite), 32'd1);
            chk("fill_wa", 32'(wa), 32'(k));
            chk("fill_wd", write_data, 32'(k * 'h11));
            if (k == 1) chk("fill_ready_after_pop", 32'(in_ready), 32'd1);
        end
        idle(1'b0);
        chk("fill_empty", 32'(empty), 32'd1);

        // bypass priority
        push(5'd5, 32'hA);
        push(5'd5, 32'hB);
        step(1'b0, 1'b0, '0, '0, 1'b0, 5'd5, 5'd0);
        chk("byp_hit1", 32'(hit1), 32'd1);
        chk("byp_byp1", byp1, 32'hB);
        chk("byp_hit2_r0", 32'(hit2), 32'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 5'd0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 5'd5, 5'd0);
        chk("byp_after_pop_hit1", 32'(hit1), 32'd1);
        chk("byp_after_pop_byp1", byp1, 32'hB);
        repeat (3) idle(1'b1);
        idle(1'b0);

        // r0 drop, then reset mid-drain
        push(5'd0, 32'h99);
        idle(1'b0);
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_empty", 32'(empty), 32'd1);
        push(5'd9, 32'h1);
        push(5'd10, 32'h2);
        push(5'd11, 32'h3);
        idle(1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b1, '0, '0);
        chk("middrain_rw", 32'(regwrite), 32'd1);
        chk("middrain_wa", 32'(wa), 32'd9);
        idle(1'b1);
        chk("postrst_rw", 32'(regwrite), 32'd0);
        chk("postrst_count", 32'(count), 32'd0);
        idle(1'b1);
        chk("postrst_rw2", 32'(regwrite), 32'd0);

        // merge scenario
        push(5'd7, 32'h1);
        push(5'd8, 32'h2);
        push(5'd7, 32'h3);
        idle(1'b0);
`ifdef WB_MERGE_EN
        chk("merge_count", 32'(count), 32'd2);
        idle(1'b1);
        idle(1'b1);
        chk("merge_wa0", 32'(wa), 32'd7);
        chk("merge_wd0", write_data, 32'h3);
        idle(1'b1);
        chk("merge_wa1", 32'(wa), 32'd8);
        chk("merge_wd1", write_data, 32'h2);
`else
        chk("nomerge_count", 32'(count), 32'd3);
        idle(1'b1);
        idle(1'b1);
        chk("nomerge_wa0", 32'(wa), 32'd7);
        chk("nomerge_wd0", write_data, 32'h1);
        idle(1'b1);
        chk("nomerge_wa1", 32'(wa), 32'd8);
        chk("nomerge_wd1", write_data, 32'h2);
        idle(1'b1);
        chk("nomerge_wa2", 32'(wa), 32'd7);
        chk("nomerge_wd2", write_data, 32'h3);
`endif
        repeat (2) idle(1'b1);

        // random traffic on a narrow address range to provoke bypass hits and merges
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Writer-side front end for the 32x32 register file: buffers completed results (dest address + data) from the execute/memory stages in a small in-order queue.
- Drains the queue one entry per cycle onto the register file's single write port (regwrite/wa/write_data).
- Exposes a two-read-port bypass lookup so decode sees values still pending in the queue or on the write port.

Parameters:
- DEPTH, 4, queue entries (power of 2, >=2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  result offered this cycle
- in_ready  output  1  queue can accept this cycle
- in_wa  input  AW  destination register
- in_data  input  DW  result value
- drain_en  input  1  permit write-port issue this cycle
- regwrite  output  1  write strobe to register file
- wa  output  AW  write address to register file
- write_data  output  DW  write data to register file
- ra1  input  AW  bypass lookup address 1
- ra2  input  AW  bypass lookup address 2
- hit1  output  1  ra1 matches a pending write
- byp1  output  DW  newest pending data for ra1
- hit2  output  1  ra2 matches a pending write
- byp2  output  DW  newest pending data for ra2
- count  output  clog2(DEPTH)+1  occupied queue entries
- empty  output  1  count==0 and regwrite==0

Behaviour:
- Reset (rst high at clk edge): count=0, rd/wr pointers=0, regwrite=0, wa=0, write_data=0. hit1/hit2=0, byp1/byp2=0 while the queue is empty. Reset mid-drain discards all pending entries; no further regwrite pulses.
- Enqueue: handshake on in_valid&&in_ready at the rising edge.
  - in_ready = (count<DEPTH), combinational from registered count only; does not depend on same-cycle pop.
  - in_wa==0 is accepted, but no entry is allocated (r0 writes are dropped).
- Issue: at each edge where drain_en=1 and count>0, the oldest entry is popped into the output register: regwrite=1, wa/write_data = entry fields, for exactly one cycle. Otherwise regwrite=0 next cycle; wa/write_data hold their last values.
  - Latency from accept to regwrite: 1 cycle minimum (accept at edge N into an empty queue, regwrite high during cycle N+1 with drain_en=1).
  - Throughput: 1 write per cycle.
- Simultaneous push and pop in one cycle: count unchanged; both happen. A push on the cycle the queue is full is impossible (in_ready=0).
- Pointers wrap modulo DEPTH. count saturates at no point; DEPTH+1 states only.
- Bypass (combinational):
  - Compare ra against every valid queue entry and against the output register when regwrite=1.
  - Priority is newest first: youngest queue entry, then older entries, then the output register.
  - ra==0 never hits. On a miss, byp=0.
  - Bypass does not see the in_* port in the same cycle.
- The register file commits write_data when sampling regwrite=1 at the rising edge. Bypass covers the output register for that cycle, so decode never sees a stale value.

Optional Feature:
- Macro WB_MERGE_EN.
- Defined:
  - If an accepted in_wa matches a valid queue entry (not the output register), the data is written in place into the youngest matching entry; no new entry is allocated and count is unchanged.
  - in_ready = (count<DEPTH) || (merge hit), with the hit computed combinationally from in_wa.
  - A merge hit on the entry being popped the same cycle instead allocates a new entry (pop wins). If the queue is also full, in_ready=0 that cycle.
- Undefined: no merging; every accept allocates an entry; in_ready = (count<DEPTH).

Test Plan:
- Reset then idle: rst 1 cycle -> regwrite=0, count=0, empty=1, in_ready=1, hit1=hit2=0.
- Single write: accept (wa=3, data=0xDEADBEEF), drain_en=1 -> next cycle regwrite=1, wa=3, write_data=0xDEADBEEF; following cycle regwrite=0, empty=1.
- Fill and backpressure: drain_en=0, push wa=1..4 with data 0x11..0x44 -> count=4, in_ready=0. Raise drain_en -> four consecutive regwrite pulses in order 1,2,3,4; in_ready=1 after the first pop.
- Bypass priority: drain_en=0, push (5,0xA), (5,0xB), ra1=5, ra2=0 -> hit1=1, byp1=0xB, hit2=0. Drain one -> byp1 still 0xB.
- r0 drop and reset mid-drain: push (0,0x99) -> count stays 0. Push 3 entries, drain 1, assert rst -> regwrite=0 and count=0 next cycle, no further writes.
- WB_MERGE_EN: drain_en=0, push (7,0x1), (8,0x2), (7,0x3) -> count=2. Drain -> writes (7,0x3) then (8,0x2). Without the macro -> count=3, writes (7,0x1), (8,0x2), (7,0x3).
